stopwatch_up: RTL and testbench
===============================

Name: stopwatch_up

Overview:
- Count-up MM:SS stopwatch: the counting-up counterpart of the countdown timer, built on the same board.
- BCD digits D3..D0 feed the existing DISP7SEG driver unchanged.
- Supports start/stop, pause, lap-hold, clear and a target-minute match LED driven from switches I3:I2.
- Has its own 1 Hz prescaler, so no external onehz instance is needed.

Parameters:
- CLK_HZ, 100000000, clk cycles per 1 s tick. Benches use 4.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start_stop  in  1  start/stop button level, debounced and synchronous; rising edge acts
- lap  in  1  lap button level; rising edge acts
- clear  in  1  clear button level; rising edge acts
- I3  in  4  target minutes tens, BCD
- I2  in  4  target minutes units, BCD
- D3  out  4  displayed minutes tens
- D2  out  4  displayed minutes units
- D1  out  4  displayed seconds tens
- D0  out  4  displayed seconds units
- running  out  1  high in RUN or LAP
- LED  out  1  sticky target-reached flag
- ErrorLED  out  1  target invalid
- ovf  out  1  high in DONE

Behaviour:
- Reset (reset=0, async):
  - State IDLE; count, lap snapshot and prescaler are 0.
  - Edge-detect registers are 0; LED=0, ovf=0, running=0; D3..D0 = 0.
- Button edges: press = input & ~registered previous value. One-cycle pulse per press; a held level gives no repeat.
- Prescaler:
  - Counts 0..CLK_HZ-1 only in RUN and LAP; tick=1 in the cycle it equals CLK_HZ-1, then it wraps to 0.
  - Holds its value in PAUSE.
  - Zeroed in IDLE, DONE and on the IDLE->RUN transition.
- Count:
  - Four BCD digits: sec units 0-9, sec tens 0-5, min units 0-9, min tens 0-5.
  - Increments at the clock edge ending a tick cycle, with ripple carry.
  - Example: 00:59 -> 01:00; 09:59 -> 10:00.
  - A tick at 59:59 leaves the count at 59:59 and moves to DONE.
- Latency: the first increment lands exactly CLK_HZ cycles after the edge that entered RUN from IDLE.
- FSM transitions; press = registered edge pulse:
  - IDLE: start -> RUN.
  - RUN: start -> PAUSE; lap -> LAP, and the snapshot captures the current count on that edge.
  - LAP: counting continues and the display shows the snapshot. lap -> RUN (display live again). start -> PAUSE (display live).
  - PAUSE: start -> RUN, count and prescaler retained. clear -> IDLE, count zeroed.
  - DONE: clear -> IDLE. All other presses are ignored.
  - clear is ignored in RUN and LAP; lap is ignored in IDLE, PAUSE and DONE.
- Simultaneous presses:
  - start and lap in the same cycle: start wins; lap is discarded.
  - clear and start in PAUSE: clear wins -> IDLE; start is discarded.
- Display: D3..D0 = snapshot in LAP, live count otherwise. Combinational mux of registers.
- ErrorLED: combinational, (I3 > 5) | (I2 > 9).
- LED:
  - Set on the edge where the count becomes {I3,I2}:00.
  - Requires ErrorLED=0 and target != 00.
  - Stays set until entry to IDLE or reset.
  - Changing I3/I2 after set does not clear it.
- ovf = (state == DONE). running = RUN | LAP.
- Reset mid-run aborts immediately to the reset state; no tick fires during or after it.

Test Plan:
- CLK_HZ=4, reset low then high, start press -> D0 becomes 1 exactly 4 cycles after the RUN-entry edge, 2 after 8; running=1.
- Run to 00:59, one more tick -> D3..D0 = 0,1,0,0; at 09:59 + tick -> 1,0,0,0.
- At 00:07 press lap -> display frozen at 00:07 while internal count reaches 00:10; press lap -> display shows 00:10 live.
- RUN with prescaler=2, press start -> PAUSE, count and prescaler held for 20 cycles; press start -> next increment after 2 cycles; then clear in RUN ignored; pause + clear -> 00:00, IDLE.
- I3=0, I2=2 -> LED rises on the edge count becomes 02:00, stays 1 at 02:05; I2=4'hA -> ErrorLED=1 and LED never sets; start+lap in same cycle from RUN -> PAUSE, not LAP.
- Run to 59:59, one more tick -> count stays 59:59, ovf=1, running=0; start ignored; clear -> IDLE, 00:00, ovf=0; async reset mid-RUN -> all outputs 0 immediately.

Source files
------------

// File: rtl/stopwatch_up.sv
// -----------------------------------------------------------------------------
// stopwatch_up
//   Count-up MM:SS stopwatch with its own 1 Hz prescaler. Four BCD digits drive
//   the existing seven-segment driver. Supports start/stop, pause, lap-hold,
//   clear, and a sticky LED that lights when the count reaches a target minute
//   value set on switches I3:I2.
//
// Parameters
//   CLK_HZ      clk cycles per one-second tick
//
// Ports
//   clk         system clock
//   reset       asynchronous, active-low reset
//   start_stop  start/stop button level (debounced, synchronous); rising edge acts
//   lap         lap button level; rising edge acts
//   clear       clear button level; rising edge acts
//   I3, I2      target minutes tens / units (BCD)
//   D3..D0      displayed MM:SS digits (lap snapshot while in LAP)
//   running     high in RUN or LAP
//   LED         sticky target-reached flag
//   ErrorLED    target switches hold an invalid value
//   ovf         high once the count has saturated at 59:59
// -----------------------------------------------------------------------------
module stopwatch_up #(
    parameter int unsigned CLK_HZ = 100000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_stop,
    input  logic       lap,
    input  logic       clear,
    input  logic [3:0] I3,
    input  logic [3:0] I2,
    output logic [3:0] D3,
    output logic [3:0] D2,
    output logic [3:0] D1,
    output logic [3:0] D0,
    output logic       running,
    output logic       LED,
    output logic       ErrorLED,
    output logic       ovf
);

    localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        LAP,
        PAUSE,
        DONE
    } state_t;

    state_t        state;
    logic [PW-1:0] presc;

    // live count digits
    logic [3:0] sec_u, sec_t, min_u, min_t;
    // lap snapshot digits
    logic [3:0] snap_su, snap_st, snap_mu, snap_mt;

    // previous button levels for edge detection
    logic start_q, lap_q, clear_q;
    logic led_q;

    logic start_p, lap_p, clear_p;
    logic counting, tick, at_max;
    logic target_ok, target_hit;
    logic [3:0] nxt_su, nxt_st, nxt_mu, nxt_mt;

    // -------------------------------------------------------------------------
    // Button edge pulses
    // -------------------------------------------------------------------------
    assign start_p = start_stop & ~start_q;
    assign lap_p   = lap        & ~lap_q;
    assign clear_p = clear      & ~clear_q;

    // -------------------------------------------------------------------------
    // Prescaler tick and saturation detect
    // -------------------------------------------------------------------------
    assign counting = (state == RUN) || (state == LAP);
    assign tick     = counting && (presc == PRESC_LAST);
    assign at_max   = (min_t == 4'd5) && (min_u == 4'd9) &&
                      (sec_t == 4'd5) && (sec_u == 4'd9);

    // -------------------------------------------------------------------------
    // Ripple-carry BCD increment of the live count. Saturation at 59:59 is
    // handled by the FSM, so min_t never needs to wrap here.
    // -------------------------------------------------------------------------
    always_comb begin
        nxt_su = sec_u;
        nxt_st = sec_t;
        nxt_mu = min_u;
        nxt_mt = min_t;
        if (sec_u == 4'd9) begin
            nxt_su = '0;
            if (sec_t == 4'd5) begin
                nxt_st = '0;
                if (min_u == 4'd9) begin
                    nxt_mu = '0;
                    nxt_mt = min_t + 4'd1;
                end else begin
                    nxt_mu = min_u + 4'd1;
                end
            end else begin
                nxt_st = sec_t + 4'd1;
            end
        end else begin
            nxt_su = sec_u + 4'd1;
        end
    end

    // -------------------------------------------------------------------------
    // Target match: only a valid, non-zero target can light the LED, and the
    // match is taken against the value the count is about to become.
    // -------------------------------------------------------------------------
    assign ErrorLED   = (I3 > 4'd5) | (I2 > 4'd9);
    assign target_ok  = ~ErrorLED && ({I3, I2} != 8'h00);
    assign target_hit = target_ok && (nxt_mt == I3) && (nxt_mu == I2) &&
                        (nxt_st == 4'd0) && (nxt_su == 4'd0);

    // -------------------------------------------------------------------------
    // Control FSM, prescaler, count, snapshot and LED
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            presc   <= '0;
            sec_u   <= '0;
            sec_t   <= '0;
            min_u   <= '0;
            min_t   <= '0;
            snap_su <= '0;
            snap_st <= '0;
            snap_mu <= '0;
            snap_mt <= '0;
            start_q <= 1'b0;
            lap_q   <= 1'b0;
            clear_q <= 1'b0;
            led_q   <= 1'b0;
        end else begin
            start_q <= start_stop;
            lap_q   <= lap;
            clear_q <= clear;

            case (state)
                IDLE: begin
                    presc <= '0;
                    if (start_p) begin
                        state <= RUN;
                    end
                end

                RUN, LAP: begin
                    if (tick) begin
                        presc <= '0;
                    end else begin
                        presc <= presc + 1'b1;
                    end

                    if (tick && at_max) begin
                        // count holds at 59:59; any press this cycle is dropped
                        state <= DONE;
                        presc <= '0;
                    end else begin
                        if (tick) begin
                            sec_u <= nxt_su;
                            sec_t <= nxt_st;
                            min_u <= nxt_mu;
                            min_t <= nxt_mt;
                            if (target_hit) begin
                                led_q <= 1'b1;
                            end
                        end

                        // start has priority over lap; clear is ignored here
                        if (start_p) begin
                            state <= PAUSE;
                        end else if (lap_p) begin
                            if (state == RUN) begin
                                state   <= LAP;
                                snap_su <= sec_u;
                                snap_st <= sec_t;
                                snap_mu <= min_u;
                                snap_mt <= min_t;
                            end else begin
                                state <= RUN;
                            end
                        end
                    end
                end

                PAUSE: begin
                    // clear has priority over start; prescaler holds otherwise
                    if (clear_p) begin
                        state   <= IDLE;
                        presc   <= '0;
                        sec_u   <= '0;
                        sec_t   <= '0;
                        min_u   <= '0;
                        min_t   <= '0;
                        snap_su <= '0;
                        snap_st <= '0;
                        snap_mu <= '0;
                        snap_mt <= '0;
                        led_q   <= 1'b0;
                    end else if (start_p) begin
                        state <= RUN;
                    end
                end

                DONE: begin
                    presc <= '0;
                    if (clear_p) begin
                        state   <= IDLE;
                        sec_u   <= '0;
                        sec_t   <= '0;
                        min_u   <= '0;
                        min_t   <= '0;
                        snap_su <= '0;
                        snap_st <= '0;
                        snap_mu <= '0;
                        snap_mt <= '0;
                        led_q   <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                    presc <= '0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: decodes of registered state only
    // -------------------------------------------------------------------------
    always_comb begin
        if (state == LAP) begin
            D3 = snap_mt;
            D2 = snap_mu;
            D1 = snap_st;
            D0 = snap_su;
        end else begin
            D3 = min_t;
            D2 = min_u;
            D1 = sec_t;
            D0 = sec_u;
        end
    end

    assign running = counting;
    assign ovf     = (state == DONE);
    assign LED     = led_q;

endmodule

// File: tb/tb_stopwatch_up.sv
module tb_stopwatch_up;

    localparam int unsigned HZ = 4;

    localparam int SEL_DISP = 0;
    localparam int SEL_RUN  = 1;
    localparam int SEL_LED  = 2;
    localparam int SEL_ERR  = 3;
    localparam int SEL_OVF  = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_stop;
    logic       lap;
    logic       clear;
    logic [3:0] I3, I2;
    logic [3:0] D3, D2, D1, D0;
    logic       running, LED, ErrorLED, ovf;

    stopwatch_up #(.CLK_HZ(HZ)) dut (
        .clk        (clk),
        .reset      (reset),
        .start_stop (start_stop),
        .lap        (lap),
        .clear      (clear),
        .I3         (I3),
        .I2         (I2),
        .D3         (D3),
        .D2         (D2),
        .D1         (D1),
        .D0         (D0),
        .running    (running),
        .LED        (LED),
        .ErrorLED   (ErrorLED),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model: elapsed seconds and prescaler phase
    int secs     = 0;
    int ph       = 0;
    bit counting = 1'b0;
    int held;

    typedef struct {
        string       tag;
        int          sel;
        logic [15:0] exp;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] bcd(input int s);
        int m, ss;
        m  = s / 60;
        ss = s % 60;
        return {4'(m / 10), 4'(m % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    function automatic logic [15:0] observe(input int sel);
        case (sel)
            SEL_DISP: return {D3, D2, D1, D0};
            SEL_RUN:  return {15'd0, running};
            SEL_LED:  return {15'd0, LED};
            SEL_ERR:  return {15'd0, ErrorLED};
            SEL_OVF:  return {15'd0, ovf};
            default:  return 16'hxxxx;
        endcase
    endfunction

    task automatic expect_val(input string tag, input int sel, input logic [15:0] exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, observe(e.sel), e.exp);
        end
    endtask

    // one clock; sample point is 1 ns after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
        if (counting) begin
            if (ph == int'(HZ) - 1) begin
                ph = 0;
                if (secs == 3599) counting = 1'b0;
                else secs++;
            end else begin
                ph++;
            end
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) step();
    endtask

    // mask: bit0 start, bit1 lap, bit2 clear; level held for one clock
    task automatic press(input int m);
        start_stop = m[0];
        lap        = m[1];
        clear      = m[2];
        step();
        start_stop = 1'b0;
        lap        = 1'b0;
        clear      = 1'b0;
    endtask

    task automatic run_to(input int target);
        int guard;
        guard = 0;
        while (secs < target && guard < 20000) begin
            step();
            guard++;
        end
        if (secs < target) check("run_to_timeout", 16'(secs), 16'(target));
    endtask

    initial begin
        reset = 1'b0;
        start_stop = 1'b0;
        lap = 1'b0;
        clear = 1'b0;
        I3 = 4'd0;
        I2 = 4'd2;
        #1;

        // ---------------- reset state ----------------
        expect_val("rst_disp", SEL_DISP, 16'h0000);
        expect_val("rst_run",  SEL_RUN,  16'd0);
        expect_val("rst_led",  SEL_LED,  16'd0);
        expect_val("rst_ovf",  SEL_OVF,  16'd0);
        expect_val("rst_err",  SEL_ERR,  16'd0);
        cyc(3);
        drain();
        reset = 1'b1;
        expect_val("idle_disp", SEL_DISP, 16'h0000);
        expect_val("idle_run",  SEL_RUN,  16'd0);
        cyc(2);
        drain();

        // ---------------- start and first-tick latency ----------------
        press(1);
        counting = 1'b1;
        ph = 0;
        expect_val("run_entry", SEL_RUN, 16'd1);
        drain();
        expect_val("pre_tick", SEL_DISP, 16'h0000);
        cyc(3);
        drain();
        expect_val("first_tick", SEL_DISP, 16'h0001);
        cyc(1);
        drain();
        expect_val("second_tick", SEL_DISP, 16'h0002);
        cyc(4);
        drain();

        // ---------------- lap hold ----------------
        run_to(7);
        press(2);
        expect_val("lap_frozen", SEL_DISP, 16'h0007);
        drain();
        run_to(10);
        expect_val("lap_hold", SEL_DISP, 16'h0007);
        expect_val("lap_running", SEL_RUN, 16'd1);
        drain();
        press(2);
        expect_val("lap_release", SEL_DISP, 16'h0010);
        drain();

        // ---------------- pause with prescaler held at 2 ----------------
        while (ph != 1) step();
        start_stop = 1'b1;
        step();
        counting = 1'b0;
        step();
        step();
        start_stop = 1'b0;
        held = secs;
        expect_val("pause_no_repeat", SEL_RUN, 16'd0);
        drain();
        expect_val("pause_hold", SEL_DISP, bcd(held));
        cyc(20);
        drain();
        press(1);
        counting = 1'b1;
        expect_val("resume_1", SEL_DISP, bcd(held));
        cyc(1);
        drain();
        expect_val("resume_2", SEL_DISP, bcd(held + 1));
        cyc(1);
        drain();
        press(4);
        expect_val("clr_ign_run", SEL_RUN, 16'd1);
        expect_val("clr_ign_disp", SEL_DISP, bcd(secs));
        drain();
        press(1);
        counting = 1'b0;
        press(4);
        secs = 0;
        ph = 0;
        expect_val("clear_disp", SEL_DISP, 16'h0000);
        expect_val("clear_run", SEL_RUN, 16'd0);
        drain();

        // ---------------- invalid target, simultaneous presses ----------------
        I2 = 4'hA;
        #1;
        expect_val("err_i2", SEL_ERR, 16'd1);
        drain();
        press(1);
        counting = 1'b1;
        ph = 0;
        run_to(20);
        expect_val("err_no_led", SEL_LED, 16'd0);
        drain();
        I3 = 4'd6; I2 = 4'd0;
        #1;
        expect_val("err_i3", SEL_ERR, 16'd1);
        drain();
        I3 = 4'd5; I2 = 4'd9;
        #1;
        expect_val("err_edge_ok", SEL_ERR, 16'd0);
        drain();
        I3 = 4'd0; I2 = 4'd2;
        step();
        press(3);
        counting = 1'b0;
        held = secs;
        expect_val("start_lap_run", SEL_RUN, 16'd0);
        expect_val("start_lap_disp", SEL_DISP, bcd(held));
        cyc(3);
        drain();
        press(2);
        expect_val("lap_in_pause", SEL_RUN, 16'd0);
        drain();
        press(4);
        secs = 0;
        ph = 0;
        expect_val("clear2_disp", SEL_DISP, 16'h0000);
        drain();

        // ---------------- carries, LED, saturation ----------------
        press(1);
        counting = 1'b1;
        ph = 0;
        expect_val("c_0059", SEL_DISP, 16'h0059);
        run_to(59);
        drain();
        expect_val("c_0100", SEL_DISP, 16'h0100);
        run_to(60);
        drain();
        expect_val("led_before", SEL_LED, 16'd0);
        run_to(119);
        drain();
        expect_val("c_0200", SEL_DISP, 16'h0200);
        expect_val("led_rise", SEL_LED, 16'd1);
        run_to(120);
        drain();
        expect_val("led_0205", SEL_LED, 16'd1);
        run_to(125);
        drain();
        I2 = 4'd7;
        #1;
        expect_val("led_sticky", SEL_LED, 16'd1);
        drain();
        I2 = 4'd2;
        expect_val("c_0959", SEL_DISP, 16'h0959);
        run_to(599);
        drain();
        expect_val("c_1000", SEL_DISP, 16'h1000);
        run_to(600);
        drain();
        expect_val("c_5959", SEL_DISP, 16'h5959);
        expect_val("pre_done_ovf", SEL_OVF, 16'd0);
        expect_val("pre_done_run", SEL_RUN, 16'd1);
        run_to(3599);
        drain();
        for (int i = 0; i < 10 && counting; i++) step();
        expect_val("done_disp", SEL_DISP, 16'h5959);
        expect_val("done_ovf", SEL_OVF, 16'd1);
        expect_val("done_run", SEL_RUN, 16'd0);
        drain();
        expect_val("done_hold", SEL_DISP, 16'h5959);
        cyc(8);
        drain();
        press(1);
        expect_val("done_start_ign", SEL_OVF, 16'd1);
        expect_val("done_start_run", SEL_RUN, 16'd0);
        drain();
        press(2);
        expect_val("done_lap_ign", SEL_OVF, 16'd1);
        expect_val("done_lap_disp", SEL_DISP, 16'h5959);
        drain();
        press(4);
        secs = 0;
        ph = 0;
        expect_val("done_clr_ovf", SEL_OVF, 16'd0);
        expect_val("done_clr_disp", SEL_DISP, 16'h0000);
        expect_val("done_clr_run", SEL_RUN, 16'd0);
        expect_val("done_clr_led", SEL_LED, 16'd0);
        drain();

        // ---------------- async reset mid-run ----------------
        press(1);
        counting = 1'b1;
        ph = 0;
        run_to(121);
        expect_val("led_pre_rst", SEL_LED, 16'd1);
        drain();
        #2;
        reset = 1'b0;
        #1;
        counting = 1'b0;
        secs = 0;
        ph = 0;
        expect_val("arst_disp", SEL_DISP, 16'h0000);
        expect_val("arst_run", SEL_RUN, 16'd0);
        expect_val("arst_led", SEL_LED, 16'd0);
        expect_val("arst_ovf", SEL_OVF, 16'd0);
        drain();
        expect_val("arst_hold", SEL_DISP, 16'h0000);
        cyc(6);
        drain();
        reset = 1'b1;
        expect_val("post_rst_disp", SEL_DISP, 16'h0000);
        expect_val("post_rst_run", SEL_RUN, 16'd0);
        expect_val("post_rst_err", SEL_ERR, 16'd0);
        cyc(8);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
